// File: rtl/sound_controller.sv
// DMA reader that fetches one half-period word per tone channel from data memory,
// commits them atomically, and drives phase-aligned square-wave outputs.
module sound_controller #(
   parameter int unsigned CHANNEL_COUNT = 3,
   parameter int unsigned SOUND_ADDR    = 7808,
   parameter int unsigned ADDR_WIDTH    = 13
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     copy_start,
   output logic [ADDR_WIDTH-1:0]    mem_din_addr,
   output logic                     mem_din_re,
   input  logic [15:0]              mem_din,
   output logic                     busy,
   output logic                     copy_done,
   output logic [CHANNEL_COUNT-1:0] sound_out
);

   localparam int unsigned IDX_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(CHANNEL_COUNT - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(SOUND_ADDR);

   typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

   state_t                 state, state_d;
   logic [IDX_W-1:0]       idx, idx_d;
   logic [ADDR_WIDTH-1:0]  addr_d;
   logic                   re_d, busy_d, done_d, commit_c;

   logic                   cap_valid;
   logic [IDX_W-1:0]       cap_idx;
   logic [15:0]            shadow [CHANNEL_COUNT];
   logic [15:0]            active [CHANNEL_COUNT];
   logic [15:0]            cnt    [CHANNEL_COUNT];

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_d  = state;
      idx_d    = idx;
      addr_d   = mem_din_addr;
      re_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      commit_c = 1'b0;
      unique case (state)
         IDLE: begin
            addr_d = BASE_ADDR;
            if (copy_start) begin
               state_d = READ;
               idx_d   = '0;
               re_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         READ: begin
            busy_d = 1'b1;
            if (idx == LAST_IDX) begin
               state_d = LAST;
            end else begin
               idx_d  = idx + IDX_W'(1);
               addr_d = BASE_ADDR + ADDR_WIDTH'(idx + IDX_W'(1));
               re_d   = 1'b1;
            end
         end
         LAST: begin
            state_d  = IDLE;
            idx_d    = '0;
            addr_d   = BASE_ADDR;
            done_d   = 1'b1;
            commit_c = 1'b1;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            addr_d  = BASE_ADDR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         mem_din_addr <= BASE_ADDR;
         mem_din_re   <= 1'b0;
         busy         <= 1'b0;
         copy_done    <= 1'b0;
      end else begin
         state        <= state_d;
         idx          <= idx_d;
         mem_din_addr <= addr_d;
         mem_din_re   <= re_d;
         busy         <= busy_d;
         copy_done    <= done_d;
      end
   end

   // Read data arrives one cycle after its address, so the index is delayed to match.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_valid <= 1'b0;
         cap_idx   <= '0;
         for (int i = 0; i < int'(CHANNEL_COUNT); i++) shadow[i] <= 16'd0;
      end else begin
         cap_valid <= (state == READ);
         cap_idx   <= idx;
         if (cap_valid) begin
            for (int i = 0; i < int'(CHANNEL_COUNT); i++)
               if (cap_idx == IDX_W'(i)) shadow[i] <= mem_din;
         end
      end
   end

   // Tone generators; the last word bypasses the shadow since it lands on the commit edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
            active[c] <= 16'd0;
            cnt[c]    <= 16'd0;
         end
         sound_out <= '0;
      end else if (commit_c) begin
         for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
            active[c] <= (c == int'(CHANNEL_COUNT) - 1) ? mem_din : shadow[c];
            cnt[c]    <= 16'd0;
         end
         sound_out <= '0;
      end else begin
         for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
            if (active[c] == 16'd0) begin
               cnt[c]       <= 16'd0;
               sound_out[c] <= 1'b0;
            end else if (cnt[c] == active[c] - 16'd1) begin
               cnt[c]       <= 16'd0;
               sound_out[c] <= ~sound_out[c];
            end else begin
               cnt[c]       <= cnt[c] + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sound_controller.sv
// Scoreboard bench for sound_controller: expected per-cycle bus activity and tone
// levels are queued at stimulus time and compared on every falling edge.
module tb_sound_controller;

   localparam int unsigned BASE = 7808;

   logic        clk = 1'b0;
   logic        reset;
   logic        copy_start;
   logic [12:0] mem_din_addr;
   logic        mem_din_re;
   logic [15:0] mem_din;
   logic        busy;
   logic        copy_done;
   logic [2:0]  sound_out;

   typedef struct packed {
      logic [12:0]      addr;
      logic             re;
      logic             busy;
      logic             done;
      logic [2:0][15:0] p;
   } exp_t;

   exp_t             sb [$];
   int               total = 0;
   int               bad   = 0;
   int               since = 0;
   logic [2:0][15:0] cur_p = '0;
   bit               mon_en = 1'b0;
   logic [15:0]      mem [0:8191];

   sound_controller dut (
      .clk          (clk),
      .reset        (reset),
      .copy_start   (copy_start),
      .mem_din_addr (mem_din_addr),
      .mem_din_re   (mem_din_re),
      .mem_din      (mem_din),
      .busy         (busy),
      .copy_done    (copy_done),
      .sound_out    (sound_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_din_re) mem_din <= mem[mem_din_addr];

   // Closed-form tone level: toggles every P cycles after the commit edge.
   function automatic logic [2:0] tone_exp();
      logic [2:0] r;
      for (int c = 0; c < 3; c++)
         r[c] = (cur_p[c] == 16'd0) ? 1'b0 : (((since / int'(cur_p[c])) % 2) == 1);
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t       e;
      logic [2:0] te;
      if (mon_en) begin
         since = since + 1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({mem_din_addr, mem_din_re, busy, copy_done} !== {e.addr, e.re, e.busy, e.done}) begin
               bad++;
               $display("FAIL ctrl t=%0t got addr=%0d re=%b busy=%b done=%b want addr=%0d re=%b busy=%b done=%b",
                        $time, mem_din_addr, mem_din_re, busy, copy_done, e.addr, e.re, e.busy, e.done);
            end
            if (e.done) begin
               cur_p = e.p;
               since = 0;
            end
         end
         te = tone_exp();
         total++;
         if (sound_out !== te) begin
            bad++;
            $display("FAIL tone t=%0t got %b want %b (since=%0d)", $time, sound_out, te, since);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_ent(input int unsigned addr, input logic re, input logic bsy, input logic done);
      exp_t e;
      e.addr = 13'(addr);
      e.re   = re;
      e.busy = bsy;
      e.done = done;
      for (int c = 0; c < 3; c++) e.p[c] = mem[BASE + c];
      sb.push_back(e);
   endtask

   task automatic push_copy(input bit prefix);
      if (prefix) push_ent(BASE, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) push_ent(BASE + k, 1'b1, 1'b1, 1'b0);
      push_ent(BASE + 2, 1'b0, 1'b1, 1'b0);
      push_ent(BASE, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic run_copy();
      push_copy(1'b1);
      copy_start = 1'b1;
      tick();
      copy_start = 1'b0;
      repeat (5) tick();
   endtask

   task automatic set_mem(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      mem[BASE] = a;
      mem[BASE + 1] = b;
      mem[BASE + 2] = c;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      copy_start = 1'b0;
      repeat (3) tick();
      total++;
      if ({mem_din_addr, mem_din_re, busy, copy_done, sound_out} !== {13'(BASE), 1'b0, 1'b0, 1'b0, 3'b000}) begin
         bad++;
         $display("FAIL reset_state got addr=%0d re=%b busy=%b done=%b snd=%b want addr=%0d zeros",
                  mem_din_addr, mem_din_re, busy, copy_done, sound_out, BASE);
      end
      mon_en = 1'b1;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      set_mem(16'd2, 16'd0, 16'd5);
      run_copy();
      repeat (30) tick();
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL basic_drain got %0d left want 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      push_copy(1'b1);
      push_copy(1'b0);
      repeat (3) push_ent(BASE, 1'b0, 1'b0, 1'b0);
      copy_start = 1'b1;
      repeat (10) tick();
      copy_start = 1'b0;
      repeat (4) tick();
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL b2b_drain got %0d left want 0", sb.size());
      end
      repeat (12) tick();
   endtask

   task automatic test_retune();
      set_mem(16'd3, 16'd3, 16'd0);
      run_copy();
      total++;
      if (sound_out[1:0] !== 2'b00) begin
         bad++;
         $display("FAIL retune_phase got %b want 00", sound_out[1:0]);
      end
      repeat (30) tick();
   endtask

   task automatic test_ignore_busy();
      int dones = 0;
      push_copy(1'b1);
      repeat (3) push_ent(BASE, 1'b0, 1'b0, 1'b0);
      copy_start = 1'b1;
      tick();
      copy_start = 1'b0;
      if (copy_done) dones++;
      tick();
      copy_start = 1'b1;
      if (copy_done) dones++;
      tick();
      copy_start = 1'b0;
      if (copy_done) dones++;
      repeat (6) begin
         tick();
         if (copy_done) dones++;
      end
      total++;
      if (dones !== 1) begin
         bad++;
         $display("FAIL ignore_busy got %0d copy_done pulses want 1", dones);
      end
      repeat (10) tick();
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      push_ent(BASE, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) push_ent(BASE + k, 1'b1, 1'b1, 1'b0);
      copy_start = 1'b1;
      tick();
      copy_start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      repeat (7) push_ent(BASE, 1'b0, 1'b0, 1'b0);
      tick();
      cur_p = '0;
      total++;
      if ({busy, mem_din_re, mem_din_addr, sound_out} !== {1'b0, 1'b0, 13'(BASE), 3'b000}) begin
         bad++;
         $display("FAIL reset_mid got busy=%b re=%b addr=%0d snd=%b want 0 0 %0d 000",
                  busy, mem_din_re, mem_din_addr, sound_out, BASE);
      end
      if (copy_done) dones++;
      tick();
      reset = 1'b0;
      if (copy_done) dones++;
      repeat (6) begin
         tick();
         if (copy_done) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL reset_mid_done got %0d pulses want 0", dones);
      end
   endtask

   task automatic test_extremes();
      int n = 0;
      set_mem(16'd1, 16'd0, 16'd0);
      run_copy();
      repeat (20) tick();
      set_mem(16'hFFFF, 16'd4, 16'd0);
      run_copy();
      while (sound_out[0] !== 1'b1 && n < 70000) begin
         tick();
         n++;
      end
      total++;
      if (n !== 65534) begin
         bad++;
         $display("FAIL max_period first toggle after %0d ticks want 65534", n);
      end
      repeat (10) tick();
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 16'd0;
      reset = 1'b1;
      copy_start = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_retune();
      test_ignore_busy();
      test_reset_mid();
      test_extremes();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/sound_controller.md
Name: sound_controller

Overview:
- DMA reader from data memory; the opposite direction of the button DMA writer.
- On copy_start it reads CHANNEL_COUNT consecutive 16-bit words from data memory, starting at SOUND_ADDR.
- The words are committed atomically as per-channel half-period values.
- Each channel drives a square-wave tone output. It sits beside the button controller on the shared data-memory port, which is granted to it after copy_start.

Parameters:
- CHANNEL_COUNT, 3, number of tone channels and number of words read.
- SOUND_ADDR, 7808, data-memory address of channel 0's word; channel i is at SOUND_ADDR+i.
- ADDR_WIDTH, 13, data-memory address width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- copy_start  input  1  request a DMA read; sampled only in IDLE.
- mem_din_addr  output  ADDR_WIDTH  data-memory read address.
- mem_din_re  output  1  read enable, high while addresses are issued.
- mem_din  input  16  read data; synchronous RAM, valid in the cycle after its address.
- busy  output  1  high while a copy is in progress.
- copy_done  output  1  one-cycle pulse after commit.
- sound_out  output  CHANNEL_COUNT  square-wave outputs, one bit per channel.

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high, exactly as fixed.

- Reset values:
  - state=IDLE, idx=0
  - mem_din_addr=SOUND_ADDR, mem_din_re=0
  - busy=0, copy_done=0
  - all active and shadow periods=0, all counters=0
  - sound_out=0

- FSM states: IDLE, READ, LAST. Cycle 0 is the cycle after the edge that samples copy_start=1 in IDLE.
  - IDLE: mem_din_addr=SOUND_ADDR, mem_din_re=0, busy=0. When copy_start=1: go to READ with idx=0.
  - READ (cycles 0..N-1, N=CHANNEL_COUNT):
    - mem_din_addr=SOUND_ADDR+idx, mem_din_re=1, busy=1.
    - idx increments each cycle.
    - When idx==N-1, next state is LAST.
  - LAST (cycle N):
    - mem_din_re=0, busy=1, mem_din_addr holds SOUND_ADDR+N-1.
    - Next state is IDLE, with idx=0.

- Capture pipeline:
  - A registered valid/index pair delays idx by one cycle. mem_din for word k is sampled at the end of cycle k+1 into shadow[k].
  - At the end of LAST, all active periods load together: words 0..N-2 from shadow, word N-1 directly from mem_din.
  - Commit is atomic: active periods never hold a mix of old and new values.

- copy_done: registered; high for exactly one cycle (cycle N+1) after commit, then low.

- Tone generation, per channel c, every cycle:
  - If active period P==0: counter=0, sound_out[c]=0.
  - Else if counter==P-1: counter=0 and sound_out[c] toggles.
  - Otherwise counter increments.
  - Net effect: output toggles every P cycles, so full period = 2P cycles. Arithmetic is 16-bit unsigned; P=1 toggles every cycle; P=65535 must not overflow.

- On commit (same edge as the active-period load): all counters=0 and all sound_out=0, so new tones start phase-aligned.
- Between commits, tones continue from the active values; the READ/LAST phases do not disturb the outputs.

- Boundary conditions:
  - copy_start held high or pulsed while busy: ignored; no restart and no extra copy.
  - copy_start still high in the cycle after copy_done: a new copy starts (IDLE samples it).
  - reset mid-copy: copy is aborted; no commit and no copy_done. Active periods clear to 0 and outputs go low.
  - CHANNEL_COUNT=1: READ lasts one cycle, then LAST.
  - Address arithmetic is ADDR_WIDTH wide with no wrap handling. SOUND_ADDR+CHANNEL_COUNT-1 must fit in ADDR_WIDTH; this is a parameter constraint.

Test Plan:
1. Memory model with 1-cycle read latency holds [7808]=2, [7809]=0, [7810]=5; pulse copy_start.
   -> mem_din_addr 7808, 7809, 7810 with re=1 in cycles 0-2; busy high cycles 0-3; copy_done high only in cycle 4.
   -> sound_out[0] toggles every 2 cycles; [1] stays 0; [2] toggles every 5 cycles.
2. Hold copy_start high for 10 cycles from IDLE.
   -> back-to-back copies, each exactly 4 busy cycles followed by one done cycle; no address skips or repeats.
3. After scenario 1, change memory to 3, 3, 0 and copy again.
   -> old tones continue through READ/LAST; at commit all outputs drop to 0 together; ch0 and ch1 then toggle every 3 cycles in phase; ch2 is silent.
4. Assert reset in cycle 2 of a copy.
   -> no copy_done; busy=0 and mem_din_re=0 the next cycle; sound_out=0; all periods 0; mem_din_addr=7808.
5. Word value 1 on ch0.
   -> sound_out[0] toggles every cycle.
   -> Word value 65535: first toggle exactly 65535 cycles after commit; counter never wraps.
6. Pulse copy_start in cycle 1 of an active copy.
   -> ignored; exactly one copy_done.
